// File: rtl/bn_stats_accum_if.sv
// rtl/bn_stats_accum_if.sv - sample stream in, mean/variance result out, valid/ready on both
// The variance operand is carried on `variance` because `var` is a reserved word.
interface bn_stats_accum_if #(
  parameter int WIDTH = 8
);
  logic signed [WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] mean;
  logic signed [WIDTH-1:0] variance;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, mean, variance, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, mean, variance, out_valid
  );
endinterface

// File: rtl/bn_stats_accum.sv
// rtl/bn_stats_accum.sv - batch mean/variance accumulator feeding the batchnorm datapath
// Optional feature macro: BN_STATS_VAR_EN builds the sum-of-squares and variance path.
module bn_stats_accum #(
  parameter int WIDTH         = 8,
  parameter int FRACTION_BITS = 8,
  parameter int LOG2N         = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  bn_stats_accum_if.slave io
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = WIDTH + LOG2N;
  localparam logic [LOG2N:0] CNT_LAST = (LOG2N+1)'(N - 1);

  typedef enum logic [1:0] {
    ACCUM     = 2'd0,
    CALC_MEAN = 2'd1,
    CALC_VAR  = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state, state_nx;

  logic signed [SW-1:0]    sum;
  logic [LOG2N:0]          cnt;
  logic signed [WIDTH-1:0] mean_q;
  logic signed [WIDTH-1:0] var_q;
  logic                    accept;
  logic                    last;
  logic                    take;

  assign accept = (state == ACCUM) && io.in_valid;
  assign last   = accept && (cnt == CNT_LAST);
  assign take   = (state == DONE) && io.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:     if (last) state_nx = CALC_MEAN;
      CALC_MEAN: state_nx = CALC_VAR;
      CALC_VAR:  state_nx = DONE;
      DONE:      if (io.out_ready) state_nx = ACCUM;
      default:   state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
    end else if (take) begin
      sum <= '0;
      cnt <= '0;
    end else if (accept) begin
      sum <= sum + {{LOG2N{io.in_data[WIDTH-1]}}, io.in_data};
      cnt <= cnt + (LOG2N+1)'(1);
    end
  end

  // Upper WIDTH bits of sum are exactly sum >>> LOG2N, floored toward -inf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_q <= '0;
    end else if (state == CALC_MEAN) begin
      mean_q <= sum[SW-1:LOG2N];
    end
  end

`ifdef BN_STATS_VAR_EN
  localparam int PW = 2 * WIDTH;
  localparam int QW = 2 * WIDTH + LOG2N;
  localparam int DW = QW + 1;
  localparam logic signed [DW-1:0] VMAX = DW'((1 << (WIDTH - 1)) - 1);

  logic [QW-1:0]           sumsq;
  logic signed [PW-1:0]    in_sq;
  logic signed [PW-1:0]    mean_sq;
  logic signed [DW-1:0]    d;
  logic signed [DW-1:0]    v;
  logic [WIDTH-1:0]        v_clamped;

  assign in_sq   = PW'(io.in_data) * PW'(io.in_data);
  assign mean_sq = PW'(mean_q) * PW'(mean_q);

  // E[x^2] - mean^2, both carrying 2*FRACTION_BITS fractional bits before rescaling.
  assign d = $signed({1'b0, sumsq >> LOG2N})
           - $signed({{(DW-PW){mean_sq[PW-1]}}, mean_sq});
  assign v = d >>> FRACTION_BITS;

  always_comb begin
    v_clamped = v[WIDTH-1:0];
    if (v < 0) begin
      v_clamped = '0;
    end else if (v > VMAX) begin
      v_clamped = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sumsq <= '0;
    end else if (take) begin
      sumsq <= '0;
    end else if (accept) begin
      sumsq <= sumsq + {{LOG2N{1'b0}}, in_sq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      var_q <= '0;
    end else if (state == CALC_VAR) begin
      var_q <= v_clamped;
    end
  end
`else
  assign var_q = '0;
`endif

  assign io.in_ready  = (state == ACCUM);
  assign io.out_valid = (state == DONE);
  assign io.mean      = mean_q;
  assign io.variance  = var_q;

endmodule

// File: doc/bn_stats_accum.md
# bn_stats_accum

Streaming batch-statistics stage placed directly upstream of the batch-normalization datapath. It consumes a stream of signed fixed-point activations, accumulates the sum and sum of squares over a batch of 2^LOG2N samples, then produces the `mean` and `var` operands that the batchnorm stage consumes. Results are held on a valid/ready output until taken, and only then does the next batch begin.

## Interface
- `WIDTH`, 8: bit width of samples and of `mean`/`var` outputs; two's complement.
- `FRACTION_BITS`, 8: fractional bits of the sample format, which is also the format of `mean` and `var`.
- `LOG2N`, 2: log2 of the batch length N; legal range 1..8.

- `clk`: input, 1 bit; single clock, rising edge.
- `rst_n`: input, 1 bit; asynchronous, active-low reset.
- `in_data`: input, WIDTH bits; signed sample.
- `in_valid`: input, 1 bit; `in_data` is valid.
- `in_ready`: output, 1 bit; block accepts a sample this cycle.
- `mean`: output, WIDTH bits; signed batch mean.
- `var`: output, WIDTH bits; signed batch variance, always >= 0.
- `out_valid`: output, 1 bit; `mean`/`var` are valid.
- `out_ready`: input, 1 bit; consumer takes the result.

## Operation
- **States:** ACCUM, CALC_MEAN, CALC_VAR, DONE.
- **ACCUM:**
  - `in_ready`=1.
  - Each cycle with `in_valid`&&`in_ready` adds the sample to `sum` (signed, WIDTH+LOG2N bits) and adds `in_data`² to `sumsq` (unsigned, 2·WIDTH+LOG2N bits). Both accumulate without overflow.
  - A counter of LOG2N+1 bits counts accepted samples. When the N-th sample is accepted, the state moves to CALC_MEAN.
- **CALC_MEAN:**
  - Registers `mean` = `sum` >>> LOG2N. This is an arithmetic shift, so it floors toward −∞; the result always fits in WIDTH bits.
  - The state then moves to CALC_VAR.
- **CALC_VAR:**
  - Computes d = (`sumsq` >> LOG2N) − (`mean`·`mean` >> FRACTION_BITS·0), in signed 2·WIDTH+LOG2N+1 bits.
  - Then computes v = d >>> FRACTION_BITS.
  - Clamps v: v<0 gives 0, and v>2^(WIDTH−1)−1 gives 2^(WIDTH−1)−1.
  - Registers v into `var` and moves to DONE.
- **DONE:**
  - `out_valid`=1 and `in_ready`=0.
  - `mean`/`var` stay stable until `out_valid`&&`out_ready`.
  - On that handshake the block clears `sum`, `sumsq` and the counter, drops `out_valid` and returns to ACCUM.
- `in_valid` is ignored in every state except ACCUM.
- `mean` and `var` hold their last values after the handshake; they change only in CALC_MEAN and CALC_VAR respectively.
- **Reset** (asynchronous, at any time, including mid-batch or in DONE): state=ACCUM, `sum`=`sumsq`=counter=0, `mean`=0, `var`=0, `out_valid`=0. `in_ready` reads 1 once `rst_n` is deasserted. Any partial batch is discarded.

## Timing
- Throughput in ACCUM: one sample per cycle.
- If the N-th sample is accepted at edge E, then `out_valid`=1 from edge E+2. A consumer that already holds `out_ready`=1 completes the handshake at edge E+3.
- `in_ready` is 0 from edge E until the output handshake edge H, and returns to 1 after H. The first sample of the next batch can be accepted at edge H+1.
- Minimum period per batch: N+3 cycles.
- All outputs are registered. `in_ready` is decoded from the state register only, with no combinational path from `out_ready` or `in_valid`.

## Configuration
- `BN_STATS_VAR_EN`:
  - **Defined:** the `sumsq` accumulator, squarer and CALC_VAR arithmetic are built, and `var` behaves as specified.
  - **Undefined:** `sumsq` and the multipliers are omitted and `var` is constant 0. CALC_VAR still occupies one cycle, so timing is identical.

## Test plan
All tests use WIDTH=8, FRACTION_BITS=0, LOG2N=2, and define `BN_STATS_VAR_EN` except test 6.
1. Samples 1,2,3,4 back-to-back -> `mean`=2, `var`=3 (7−4); `out_valid` rises 2 edges after the 4th accept.
2. Samples −1,0,0,0 -> `mean`=−1 (floor); d=0−1=−1, clamped -> `var`=0.
3. Samples −128,127,−128,127 -> `mean`=−1; `sumsq`>>2=16256, minus 1 = 16255, saturated -> `var`=127.
4. Batch 5,5,5,5 with `out_ready`=0 for 6 cycles while `in_valid`=1 -> `mean`=5, `var`=0 held stable, `in_ready`=0 throughout, no sample absorbed. Then pulse `out_ready` -> `in_ready`=1 the next cycle, and the next batch −4,−4,−4,−4 gives `mean`=−4, `var`=0.
5. Accept 10,20, then assert `rst_n` low for 1 cycle mid-batch -> `out_valid`=0, `mean`=`var`=0. Then feed 1,2,3,4 -> `mean`=2, `var`=3 (the partial batch is discarded).
6. Without `BN_STATS_VAR_EN`, feed 1,2,3,4 -> `mean`=2, `var`=0, same latency as test 1.
